// File: rtl/video_daisy_ctrl_pkg.sv
// Shared types and constants for the key-triggered Avalon-MM control writer.
package video_daisy_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    localparam int AVS_DATA_W_DEFAULT = 32;

    localparam logic AVS_CTRL_ADDR = 1'b0;

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces an active-low pushbutton.
// Emits a one-cycle registered press pulse on each debounced 1->0 transition.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             key_meta;
    logic             key_s;
    logic             key_db;
    logic             key_db_d;
    logic [CNT_W-1:0] cnt;

    // The debounced level only follows key_s after it has differed for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_meta <= 1'b1;
            key_s    <= 1'b1;
            key_db   <= 1'b1;
            key_db_d <= 1'b1;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            key_meta <= key_n;
            key_s    <= key_meta;
            if (key_s == key_db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                key_db <= key_s;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            key_db_d <= key_db;
            press    <= key_db_d & ~key_db;
        end
    end

endmodule

// File: rtl/video_daisy_key_avs_writer.sv
// Captures one switch bit per video core on a debounced key press and writes each core's control register in turn.
// Optional macro VIDEO_DAISY_AUTO_REFRESH_EN: synchronised switch changes also start (or queue) a sequence.
module video_daisy_key_avs_writer
    import video_daisy_ctrl_pkg::*;
#(
    parameter int N_CORE          = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int AVS_DATA_W      = AVS_DATA_W_DEFAULT
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         key_n,
    input  logic [N_CORE-1:0]            sw,
    input  logic [N_CORE-1:0]            avs_waitrequest,
    output logic [N_CORE-1:0]            avs_write,
    output logic [N_CORE-1:0]            avs_address,
    output logic [N_CORE*AVS_DATA_W-1:0] avs_writedata,
    output logic                         busy,
    output logic                         done_pulse
);

    localparam int IDX_W = (N_CORE > 1) ? $clog2(N_CORE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CORE - 1);

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  idx;
    logic [N_CORE-1:0] sw_q;
    logic [N_CORE-1:0] wd_q;
    logic [N_CORE-1:0] wd_bits;
    logic              pending;
    logic              press;
    logic              trigger;
    logic              accept;
    logic              restart;
    logic [N_CORE-1:0] sw_src;
    logic              refresh_req;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .key_n (key_n),
        .press (press)
    );

`ifdef VIDEO_DAISY_AUTO_REFRESH_EN
    logic [N_CORE-1:0] sw_meta;
    logic [N_CORE-1:0] sw_sync;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    assign sw_src      = sw_sync;
    assign refresh_req = (sw_sync != sw_q);
`else
    assign sw_src      = sw;
    assign refresh_req = 1'b0;
`endif

    assign trigger = press | refresh_req;
    assign accept  = (state == WRITE) && !avs_waitrequest[idx];
    assign restart = (state == DONE) && (pending || trigger);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trigger) state_next = WRITE;
            WRITE:   if (accept && (idx == LAST_IDX)) state_next = DONE;
            DONE:    state_next = restart ? WRITE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A trigger that lands while a sequence is running is remembered once and replayed straight from DONE.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            idx     <= '0;
            sw_q    <= '0;
            wd_q    <= '0;
            pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        sw_q <= sw_src;
                        idx  <= '0;
                    end
                end
                WRITE: begin
                    if (trigger) pending <= 1'b1;
                    if (accept) begin
                        wd_q[idx] <= sw_q[idx];
                        if (idx != LAST_IDX) idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (restart) begin
                        pending <= 1'b0;
                        sw_q    <= sw_src;
                        idx     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // The selected core shows its new bit immediately; every other slice keeps its last accepted value.
    always_comb begin
        avs_write  = '0;
        wd_bits    = wd_q;
        busy       = (state != IDLE);
        done_pulse = (state == DONE);
        if (state == WRITE) begin
            avs_write[idx] = 1'b1;
            wd_bits[idx]   = sw_q[idx];
        end
    end

    always_comb begin
        avs_writedata = '0;
        for (int i = 0; i < N_CORE; i++) begin
            avs_writedata[i*AVS_DATA_W] = wd_bits[i];
        end
    end

    assign avs_address = {N_CORE{AVS_CTRL_ADDR}};

endmodule
